// File: rtl/wshb_rr_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter.
package wshb_rr_arbiter_pkg;

    // Arbiter ownership states: nobody, requester 0, requester 1.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    // Default number of contended cycles an owner keeps the bus before preemption.
    localparam int MAX_HOLD_DEFAULT = 64;

endpackage

// File: rtl/wshb_rr_arbiter_if.sv
// Classic Wishbone B4 bus bundle; master drives the request side, slave answers.
interface wshb_if #(
    parameter int DATA_BYTES = 4
) ();
    localparam int DW = 8 * DATA_BYTES;

    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [31:0]           adr;
    logic [DW-1:0]         dat_ms;
    logic [DW-1:0]         dat_sm;
    logic [DATA_BYTES-1:0] sel;
    logic [2:0]            cti;
    logic [1:0]            bte;
    logic                  ack;
    logic                  err;
    logic                  rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/wshb_rr_arbiter.sv
// Two-requester Wishbone arbiter in front of the shared SDRAM slave.
// Requester 0 (video reader) wins the first tie after reset; afterwards ties
// alternate. An owner that keeps cyc high while the other side waits is
// preempted after MAX_HOLD cycles, but only in a cycle where its stb is low,
// so an outstanding transfer is never cut in half.
module wshb_rr_arbiter
    import wshb_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    wshb_if.slave      wshb_ifs0,
    wshb_if.slave      wshb_ifs1,
    wshb_if.master     wshb_ifm,
    output logic [1:0] gnt
);

    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_e        state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              other_waiting;

    // State, last-owner and hold counter registers; reset aborts any grant at once.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_q       <= hold_d;
        end
    end

    // The non-owner is waiting whenever it holds cyc high during a grant.
    assign other_waiting = ((state_q == GNT0) && wshb_ifs1.cyc) ||
                           ((state_q == GNT1) && wshb_ifs0.cyc);

    // Next-state: fair tie-break in IDLE, direct hand-over, stb-safe preemption.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wshb_ifs0.cyc && wshb_ifs1.cyc)
                    state_d = last_owner_q ? GNT0 : GNT1;
                else if (wshb_ifs0.cyc)
                    state_d = GNT0;
                else if (wshb_ifs1.cyc)
                    state_d = GNT1;
            end
            GNT0: begin
                if (!wshb_ifs0.cyc)
                    state_d = wshb_ifs1.cyc ? GNT1 : IDLE;
                else if (wshb_ifs1.cyc && (hold_q == HOLD_MAX) && !wshb_ifs0.stb)
                    state_d = GNT1;
            end
            GNT1: begin
                if (!wshb_ifs1.cyc)
                    state_d = wshb_ifs0.cyc ? GNT0 : IDLE;
                else if (wshb_ifs0.cyc && (hold_q == HOLD_MAX) && !wshb_ifs1.stb)
                    state_d = GNT0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold counter restarts on every grant change; last-owner follows each new grant.
    always_comb begin
        last_owner_d = last_owner_q;
        hold_d       = hold_q;
        if (state_d != state_q) begin
            hold_d = '0;
            if (state_d == GNT0)
                last_owner_d = 1'b0;
            else if (state_d == GNT1)
                last_owner_d = 1'b1;
        end else if (other_waiting && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    // Output mux: owner's request passes straight through, responses go to the owner only.
    always_comb begin
        wshb_ifm.cyc    = 1'b0;
        wshb_ifm.stb    = 1'b0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.adr    = '0;
        wshb_ifm.dat_ms = '0;
        wshb_ifm.sel    = '0;
        wshb_ifm.cti    = '0;
        wshb_ifm.bte    = '0;
        wshb_ifs0.ack   = 1'b0;
        wshb_ifs0.err   = 1'b0;
        wshb_ifs0.rty   = 1'b0;
        wshb_ifs1.ack   = 1'b0;
        wshb_ifs1.err   = 1'b0;
        wshb_ifs1.rty   = 1'b0;
        case (state_q)
            GNT0: begin
                wshb_ifm.cyc    = wshb_ifs0.cyc;
                wshb_ifm.stb    = wshb_ifs0.stb;
                wshb_ifm.we     = wshb_ifs0.we;
                wshb_ifm.adr    = wshb_ifs0.adr;
                wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
                wshb_ifm.sel    = wshb_ifs0.sel;
                wshb_ifm.cti    = wshb_ifs0.cti;
                wshb_ifm.bte    = wshb_ifs0.bte;
                wshb_ifs0.ack   = wshb_ifm.ack;
                wshb_ifs0.err   = wshb_ifm.err;
                wshb_ifs0.rty   = wshb_ifm.rty;
            end
            GNT1: begin
                wshb_ifm.cyc    = wshb_ifs1.cyc;
                wshb_ifm.stb    = wshb_ifs1.stb;
                wshb_ifm.we     = wshb_ifs1.we;
                wshb_ifm.adr    = wshb_ifs1.adr;
                wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
                wshb_ifm.sel    = wshb_ifs1.sel;
                wshb_ifm.cti    = wshb_ifs1.cti;
                wshb_ifm.bte    = wshb_ifs1.bte;
                wshb_ifs1.ack   = wshb_ifm.ack;
                wshb_ifs1.err   = wshb_ifm.err;
                wshb_ifs1.rty   = wshb_ifm.rty;
            end
            default: ;
        endcase
    end

    // Read data is harmless to broadcast; only the owner gets an ack to qualify it.
    assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;

    // Grant LEDs come straight from the state register, so they never glitch.
    assign gnt = {(state_q == GNT1), (state_q == GNT0)};

endmodule

// File: doc/wshb_rr_arbiter.md
WSHB_RR_ARBITER -- requirements
Module: wshb_rr_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 64: cycles an owner may keep a grant while the other master waits before it can be preempted.
REQ-002 SHALL have port sys_clk, input, 1 bit: system clock (100 MHz).
REQ-003 SHALL have port sys_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port wshb_ifs0, wshb_if slave modport, DATA_BYTES=4: requester 0, the video framebuffer reader, with higher reset priority.
REQ-005 SHALL have port wshb_ifs1, wshb_if slave modport, DATA_BYTES=4: requester 1, the pixel writer/pattern generator.
REQ-006 SHALL have port wshb_ifm, wshb_if master modport, DATA_BYTES=4: shared SDRAM slave.
REQ-007 SHALL have port gnt, output, 2 bits: one-hot current owner (bit0 = requester 0, bit1 = requester 1), 00 when idle; intended for LED display.

Function
REQ-008 SHALL implement registered FSM states IDLE, GNT0, GNT1, plus a 1-bit last-owner register.
REQ-009 In IDLE, a requester is requesting when its cyc=1.
REQ-010 In IDLE, when exactly one requester is requesting, the FSM SHALL move to that requester's GNT state on the next sys_clk edge.
REQ-011 In IDLE, when both are requesting, the FSM SHALL grant the requester that is not last-owner.
REQ-012 From GNTx, when the owner drops cyc and the other requester's cyc=1, the FSM SHALL move directly to the other requester's GNT state with no IDLE cycle.
REQ-013 From GNTx, when the owner drops cyc and the other requester's cyc=0, the FSM SHALL return to IDLE.
REQ-014 Preemption: a hold counter SHALL count cycles in GNTx while the other requester's cyc=1 and SHALL clear on every grant change.
REQ-015 When the hold counter reaches MAX_HOLD and the owner has stb=0, the grant SHALL pass to the other requester on the next edge; while stb=1, preemption SHALL wait, because a transfer may be outstanding.
REQ-016 A preempted requester whose cyc is still high SHALL be treated as requesting and is regranted by the normal rules.
REQ-017 Last-owner SHALL update on every entry into GNT0 or GNT1.
REQ-018 In GNTx, wshb_ifm cyc, stb, we, adr, dat_ms, sel, cti and bte SHALL be combinational copies of the owner's signals.
REQ-019 In IDLE, wshb_ifm cyc and stb SHALL be 0, and all other wshb_ifm outputs SHALL be 0.
REQ-020 The owner SHALL receive ack, err and rty from wshb_ifm combinationally.
REQ-021 The non-owner SHALL see ack=0, err=0 and rty=0; its stalled stb is legal Wishbone wait behaviour.
REQ-022 dat_sm SHALL be broadcast to both requesters.
REQ-023 Grant latency SHALL be one cycle from cyc assertion in IDLE to the first stb reaching wshb_ifm; after that, the path SHALL add zero latency.
REQ-024 The hold counter SHALL saturate at MAX_HOLD, and its width SHALL be $clog2(MAX_HOLD+1).
REQ-025 gnt SHALL be decoded from the FSM state only (registered, glitch-free).

Reset
REQ-026 On sys_rst assertion, the FSM SHALL be IDLE, last-owner SHALL be 1 (so requester 0 wins the first tie), the hold counter SHALL be 0, and gnt SHALL be 00.
REQ-027 On sys_rst assertion, all wshb_ifm outputs SHALL be 0 and ack/err/rty to both requesters SHALL be 0.
REQ-028 Reset mid-transfer SHALL abort the grant immediately (asynchronously); the arbiter SHALL re-arbitrate from IDLE after release.
REQ-029 Reset SHALL be released synchronously to sys_clk by the existing reset logic; the arbiter SHALL contain no additional synchronizer.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, GNT0, GNT1) and the MAX_HOLD default constant.
REQ-031 The block SHALL be a single module with no sub-module; muxing and FSM SHALL stay local.
REQ-032 Instantiation SHALL be in the top level, between the video reader, the pattern writer and the wshb_if_sdram bus, replacing the current tie-offs.

Verification
REQ-033 Single request: requester 0 raises cyc/stb with adr=0x100 in IDLE -> gnt=01 after 1 cycle; wshb_ifm.adr=0x100; the ack routed to requester 0 only.
REQ-034 Tie after reset: both raise cyc in the same cycle -> gnt=01. Requester 0 drops cyc -> gnt=10 on the next edge with no IDLE cycle. Both re-request later -> requester 0 wins again, since requester 1 was last-owner.
REQ-035 Preemption: MAX_HOLD=4, requester 0 holds cyc with stb pulsing, requester 1 waiting -> grant moves to requester 1 at the first stb=0 cycle at or after 4 waiting cycles; never while requester 0 stb=1.
REQ-036 Non-owner isolation: requester 1 stb=1 while gnt=01 -> requester 1 sees ack=0 throughout, and its adr never appears on wshb_ifm.
REQ-037 Reset mid-burst: assert sys_rst during a requester 1 cti=010 burst -> wshb_ifm.cyc=0 and gnt=00 immediately. After release, with only requester 1 requesting -> gnt=10 after 1 cycle.
REQ-038 Idle: no requests for 100 cycles -> wshb_ifm cyc=stb=0, gnt=00, hold counter stays 0.
